uart_rx_pkt_ctrl: RTL



---
 rtl/uart_rx_pkt_ctrl_pkg.sv | 29 ++
 rtl/uart_rx_pkt_ctrl_pkt_buf.sv | 28 ++
 rtl/uart_rx_pkt_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared definitions for the UART packet controller: FSM state encoding,
// error codes, default parameter values and a small state helper.
package uart_rx_pkt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_COMMIT  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hAA;
  localparam int         DEF_MAX_LEN     = 16;
  localparam int         DEF_TIMEOUT_CYC = 8680;

  // True in the states that wait for a byte of an open packet; these are the
  // states in which the inter-byte timeout runs.
  function automatic logic in_packet(state_t s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_pkt_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and one
// asynchronous read port. Async read lets COMMIT issue a write every cycle.
module uart_rx_pkt_ctrl_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Each entry captures the write data when it is the addressed slot.
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART byte receiver. Hunts for a sync byte,
// collects ADDR, LEN, payload and CSUM, and on a zero modulo-256 sum replays
// the buffered payload as back-to-back writes on the register-bank port.
module uart_rx_pkt_ctrl
  import uart_rx_pkt_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         MAX_LEN     = DEF_MAX_LEN,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_rcv,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state_reg;
  logic [7:0]    base_reg;
  logic [7:0]    len_reg;
  logic [7:0]    sum_reg;
  logic [7:0]    idx_reg;
  logic [TW-1:0] tmo_cnt_reg;

  logic [7:0]    sum_next;
  logic          tmo_expire;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

  uart_rx_pkt_ctrl_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_pkt_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (rx_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Running checksum, timeout detect and buffer port steering.
  always_comb begin
    sum_next   = sum_reg + rx_data;
    tmo_expire = in_packet(state_reg) && (tmo_cnt_reg == TMO_LAST);
    buf_we     = rx_rcv && (state_reg == ST_PAYLOAD) && !tmo_expire;
    buf_waddr  = idx_reg[AW-1:0];
    // CSUM launches the first write from slot 0; COMMIT walks idx.
    buf_raddr  = (state_reg == ST_COMMIT) ? idx_reg[AW-1:0] : '0;
  end

  // Packet FSM with registered write port, pulses and sticky error code.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= ST_HUNT;
      base_reg    <= 8'd0;
      len_reg     <= 8'd0;
      sum_reg     <= 8'd0;
      idx_reg     <= 8'd0;
      tmo_cnt_reg <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= 8'd0;
      wr_data     <= 8'd0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      wr_en    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (tmo_expire) begin
        // Expiry beats a byte arriving in the same cycle; that byte is lost.
        pkt_err     <= 1'b1;
        err_code    <= ERR_TIMEOUT;
        state_reg   <= ST_HUNT;
        tmo_cnt_reg <= '0;
      end else begin
        if (in_packet(state_reg)) begin
          tmo_cnt_reg <= rx_rcv ? '0 : tmo_cnt_reg + 1'b1;
        end else begin
          tmo_cnt_reg <= '0;
        end
        case (state_reg)
          ST_HUNT: begin
            if (rx_rcv && (rx_data == SYNC_BYTE)) begin
              sum_reg   <= 8'd0;
              state_reg <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (rx_rcv) begin
              base_reg  <= rx_data;
              sum_reg   <= sum_next;
              state_reg <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_rcv) begin
              sum_reg <= sum_next;
              len_reg <= rx_data;
              idx_reg <= 8'd0;
              if (rx_data > MAX_LEN_B) begin
                pkt_err   <= 1'b1;
                err_code  <= ERR_LEN;
                state_reg <= ST_HUNT;
              end else if (rx_data == 8'd0) begin
                state_reg <= ST_CSUM;
              end else begin
                state_reg <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_rcv) begin
              sum_reg <= sum_next;
              idx_reg <= idx_reg + 8'd1;
              if ((idx_reg + 8'd1) == len_reg) begin
                state_reg <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (rx_rcv) begin
              sum_reg <= sum_next;
              if (sum_next == 8'd0) begin
                state_reg <= ST_COMMIT;
                // Issue write 0 here so it appears the cycle after the CSUM byte.
                if (len_reg != 8'd0) begin
                  wr_en   <= 1'b1;
                  wr_addr <= base_reg;
                  wr_data <= buf_rdata;
                  idx_reg <= 8'd1;
                end else begin
                  idx_reg <= 8'd0;
                end
              end else begin
                pkt_err   <= 1'b1;
                err_code  <= ERR_CSUM;
                state_reg <= ST_HUNT;
              end
            end
          end
          ST_COMMIT: begin
            // Incoming bytes are ignored while the burst drains.
            if (idx_reg == len_reg) begin
              pkt_done  <= 1'b1;
              err_code  <= ERR_NONE;
              state_reg <= ST_HUNT;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= base_reg + idx_reg;
              wr_data <= buf_rdata;
              idx_reg <= idx_reg + 8'd1;
            end
          end
          default: begin
            state_reg <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign busy = (state_reg != ST_HUNT);

endmodule
